// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned PC_STEP_DEF = 4;
  localparam int unsigned CNT_W       = 16;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  next_pc;
  } fetch_entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer with flush; flush overrides push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_flush,
  input  logic   i_push,
  input  logic   i_pop,
  input  entry_t i_wdata,
  output entry_t o_rdata,
  output logic   o_full,
  output logic   o_empty
);

  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_BITS-1:0] r_count;
  entry_t              r_mem [DEPTH];

  logic w_wr;
  logic w_rd;

  assign o_full  = (r_count == CNT_BITS'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_head];

  // A push into a full buffer is accepted only alongside a pop.
  assign w_wr = i_push & ~i_flush & (~o_full | i_pop);
  assign w_rd = i_pop & ~i_flush & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_tail <= r_tail + PTR_W'(1);
      if (w_rd) r_head <= r_head + PTR_W'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_BITS'(1);
        2'b01:   r_count <= r_count - CNT_BITS'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_tail] <= i_wdata;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: PC register, PC+step adder and a prefetch queue feeding decode.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_STEP  = PC_STEP_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               Clk,
  input  logic               Clr,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               id_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_next_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_W-1:0]   fetch_stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  next_pc;
  } entry_t;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_full;
  logic              w_empty;
  logic              w_deq;
  logic              w_enq;
  entry_t            w_wdata;
  entry_t            w_rdata;

  assign w_pc_next = r_pc + ADDR_W'(PC_STEP);
  assign rom_addr  = r_pc;

  assign out_valid = ~w_empty;
  assign w_deq     = out_valid & id_ready;
  assign w_enq     = ~branch_taken & (~w_full | w_deq);

  assign w_wdata.instr   = rom_data;
  assign w_wdata.next_pc = w_pc_next;

  assign out_instr   = out_valid ? w_rdata.instr : '0;
  assign out_next_pc = out_valid ? w_rdata.next_pc : '0;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_pc <= ADDR_W'(RESET_PC);
    end else if (branch_taken) begin
      r_pc <= branch_target;
    end else if (w_enq) begin
      r_pc <= w_pc_next;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst_n (Clr),
    .i_flush (branch_taken),
    .i_push  (w_enq),
    .i_pop   (w_deq),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (branch_taken) r_flush_cnt <= sat_inc(r_flush_cnt);
      if (w_full && !w_deq && !branch_taken) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign fetch_stall_cnt = r_stall_cnt;
  assign flush_cnt       = r_flush_cnt;
`endif

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch front end for the pipelined ARM core. It merges the PC register, PC+4 adder and IF/ID hand-off into one block, and adds a DEPTH-entry prefetch queue. The queue lets fetch run ahead of a stalled decode stage. A taken branch redirects the PC and flushes everything prefetched. It sits between the instruction ROM (asynchronous read) and the decode/control-unit stage.

## Interface
- ADDR_W, 8, PC and ROM address width
- INSTR_W, 32, instruction width
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- PC_STEP, 4, PC increment per fetched instruction
- RESET_PC, 0, PC value after reset
- Clk  input  1  clock; all state changes on rising edge
- Clr  input  1  asynchronous, active-low reset
- rom_addr  output  ADDR_W  fetch address to ROM; equals the PC register
- rom_data  input  INSTR_W  ROM read data for rom_addr, same cycle
- branch_taken  input  1  redirect request from the later stage
- branch_target  input  ADDR_W  redirect address
- id_ready  input  1  decode accepts the head entry this cycle
- out_valid  output  1  head entry valid
- out_instr  output  INSTR_W  head instruction; 0 when out_valid=0
- out_next_pc  output  ADDR_W  PC+PC_STEP of the head instruction; 0 when out_valid=0
- fetch_stall_cnt  output  16  cycles fetch was blocked by a full queue (FETCH_PERF_EN only)
- flush_cnt  output  16  taken redirects (FETCH_PERF_EN only)

## Operation
- deq = out_valid & id_ready.
- enq = !branch_taken & (count<DEPTH | deq).
- On enq:
  - write {rom_data, pc+PC_STEP} at the tail.
  - pc <= pc+PC_STEP, modulo 2^ADDR_W (wrap from 2^ADDR_W−PC_STEP to 0).
- On deq without branch_taken: advance the head.
- Simultaneous enq and deq: count unchanged. This is legal when full.
- On branch_taken:
  - pc <= branch_target.
  - count <= 0 and head = tail pointers reset; all queued entries are discarded, including one being dequeued that cycle.
  - No enqueue that cycle.
  - branch_taken has priority over everything.
- The handshake is valid/ready. out_instr and out_next_pc stay stable while out_valid=1 and id_ready=0.
- out_valid = (count!=0).
- No explicit FSM. The state is pc, head/tail pointers and count (0..DEPTH).

## Timing
- Reset values:
  - pc=RESET_PC, so rom_addr=RESET_PC.
  - count=0; pointers 0.
  - out_valid=0, out_instr=0, out_next_pc=0.
  - Both counters 0.
- First instruction: after Clr releases, the first rising edge enqueues ROM[RESET_PC]. out_valid=1 from that edge onward.
- Fetch-to-decode latency: 1 cycle when the queue is empty.
- Sustained throughput: 1 instruction/cycle with id_ready held high.
- Redirect: out_valid=0 in the cycle after the branch edge. The first target instruction is valid one edge later.
- Full queue with id_ready=0: pc holds, and rom_addr holds.
- Clr asserted mid-operation: all state returns immediately to reset values, independent of Clk.

## Configuration
- FETCH_PERF_EN defined: both 16-bit counters are implemented and saturate at 0xFFFF.
  - fetch_stall_cnt increments each cycle with count==DEPTH, !deq and !branch_taken.
  - flush_cnt increments on each branch_taken cycle.
- Not defined: the counter ports are absent and no counter logic is built.

## Structure
- fetch_pkg holds:
  - default ADDR_W, INSTR_W and PC_STEP constants;
  - the queue entry struct {instr, next_pc};
  - the counter width.
- One sub-module, fetch_fifo: a circular buffer with a flush input. It handles storage, pointers, count and full/empty.
- The PC register, the adder and the enq/deq logic stay in the top module.

## Test plan
- Reset, ROM[0..3]=E3A00001,E3A01002,E0802001,EAFFFFFE, id_ready=1 → out_instr follows that sequence on consecutive cycles; out_next_pc=4,8,12,16.
- id_ready=0 for 6 cycles, DEPTH=4 → count reaches 4, rom_addr freezes at 16, fetch_stall_cnt=2; releasing id_ready drains in order without loss.
- Queue full, id_ready=1 for one cycle → one dequeue and one enqueue in the same cycle; count stays 4.
- branch_taken with branch_target=0x40 while 3 entries are queued → out_valid=0 on the next cycle, then ROM[0x40] appears with out_next_pc=0x44; flush_cnt=1.
- PC at 0xFC, ADDR_W=8 → next fetch address is 0x00, and out_next_pc for that entry is 0x00.
- Clr pulsed low asynchronously mid-stream → out_valid drops immediately, rom_addr=RESET_PC, and fetch restarts normally.
